// File: rtl/fb_mem_responder_pkg.sv
// Shared types for the framebuffer memory responder: FSM states, requester
// identities and the RAM byte-enable rule.
package fb_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK
   } fb_resp_state_t;

   typedef enum logic {
      REQ_VGA,
      REQ_CPU
   } fb_requester_t;

   localparam logic [1:0] BE_ALL = 2'b11;

   // Writes use the CPU byte selects; every read fetches the full word.
   function automatic logic [1:0] ram_be_for(input logic wr, input logic [1:0] bytesel);
      return wr ? bytesel : BE_ALL;
   endfunction

endpackage

// File: rtl/fb_rd_latency_counter.sv
// Counts the RAM read-latency cycles spent in WAIT and flags the cycle in
// which ram_rdata is valid and must be captured.
module fb_rd_latency_counter #(
   parameter int RD_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic capture
);

   logic [1:0] cnt;

   // Load the latency when the read is issued, then count down once per WAIT cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= 2'd0;
      end else if (load) begin
         cnt <= 2'(RD_LATENCY);
      end else if (en && (cnt != 2'd0)) begin
         cnt <= cnt - 2'd1;
      end
   end

   assign capture = en && (cnt == 2'd1);

endmodule

// File: rtl/fb_mem_responder.sv
// Framebuffer memory responder: arbitrates VGA prefetch reads and CPU
// word/byte accesses onto one single-port synchronous video RAM.
module fb_mem_responder
   import fb_mem_responder_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fb_access,
   input  logic [15:0] fb_address,
   output logic        fb_ack,
   output logic [15:0] fb_data,
   input  logic        cpu_access,
   input  logic        cpu_wr_en,
   input  logic [15:0] cpu_address,
   input  logic [1:0]  cpu_bytesel,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   output logic [15:0] ram_addr,
   output logic        ram_wr_en,
   output logic [1:0]  ram_be,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata
);

   fb_resp_state_t state_q, state_d;
   fb_requester_t  req_q, last_q;
   logic           wr_q;
   logic           grant, grant_vga, go_ack, ld_cnt, cnt_en, capture;

   fb_rd_latency_counter #(
      .RD_LATENCY (RD_LATENCY)
   ) u_lat (
      .clk     (clk),
      .reset   (reset),
      .load    (ld_cnt),
      .en      (cnt_en),
      .capture (capture)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state, grant decision and sequencing strobes.
   always_comb begin
      state_d   = state_q;
      grant     = 1'b0;
      grant_vga = 1'b0;
      go_ack    = 1'b0;
      ld_cnt    = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (fb_access || cpu_access) begin
               grant = 1'b1;
               // VGA wins a tie only when the CPU had the previous grant.
               grant_vga = fb_access && (!cpu_access || (last_q == REQ_CPU));
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (wr_q) begin
               state_d = ACK;
               go_ack  = 1'b1;
            end else begin
               state_d = WAIT;
               ld_cnt  = 1'b1;
            end
         end
         WAIT: begin
            cnt_en = 1'b1;
            if (capture) begin
               state_d = ACK;
               go_ack  = 1'b1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered RAM drive, read-data capture and ack pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         req_q     <= REQ_VGA;
         last_q    <= REQ_CPU;
         wr_q      <= 1'b0;
         ram_addr  <= '0;
         ram_be    <= '0;
         ram_wdata <= '0;
         ram_wr_en <= 1'b0;
         fb_data   <= '0;
         cpu_rdata <= '0;
         fb_ack    <= 1'b0;
         cpu_ack   <= 1'b0;
      end else begin
         ram_wr_en <= 1'b0;
         fb_ack    <= 1'b0;
         cpu_ack   <= 1'b0;
         if (grant) begin
            if (grant_vga) begin
               req_q    <= REQ_VGA;
               last_q   <= REQ_VGA;
               wr_q     <= 1'b0;
               ram_addr <= fb_address;
               ram_be   <= BE_ALL;
            end else begin
               req_q     <= REQ_CPU;
               last_q    <= REQ_CPU;
               wr_q      <= cpu_wr_en;
               ram_addr  <= cpu_address;
               ram_be    <= ram_be_for(cpu_wr_en, cpu_bytesel);
               ram_wdata <= cpu_wdata;
               // An empty byte mask still runs the sequence but never strobes the RAM.
               ram_wr_en <= cpu_wr_en && (cpu_bytesel != 2'b00);
            end
         end
         if (capture) begin
            if (req_q == REQ_VGA) fb_data   <= ram_rdata;
            else                  cpu_rdata <= ram_rdata;
         end
         if (go_ack) begin
            fb_ack  <= (req_q == REQ_VGA);
            cpu_ack <= (req_q == REQ_CPU);
         end
      end
   end

endmodule

// File: tb/tb_fb_mem_responder.sv
// Self-checking bench for fb_mem_responder: one instance at RD_LATENCY=1 and
// one at RD_LATENCY=3, each with its own behavioural video RAM.
module tb_fb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        fb_access1, cpu_access1, cpu_wr_en1;
   logic [15:0] fb_address1, cpu_address1, cpu_wdata1;
   logic [1:0]  cpu_bytesel1;
   logic        fb_ack1, cpu_ack1, ram_wr_en1;
   logic [15:0] fb_data1, cpu_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
   logic [1:0]  ram_be1;

   logic        fb_access3, cpu_access3, cpu_wr_en3;
   logic [15:0] fb_address3, cpu_address3, cpu_wdata3;
   logic [1:0]  cpu_bytesel3;
   logic        fb_ack3, cpu_ack3, ram_wr_en3;
   logic [15:0] fb_data3, cpu_rdata3, ram_addr3, ram_wdata3, ram_rdata3;
   logic [1:0]  ram_be3;

   logic [15:0] mem1 [0:65535];
   logic [15:0] mem3 [0:65535];
   logic [15:0] p3a, p3b;

   fb_mem_responder #(.RD_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .fb_access(fb_access1), .fb_address(fb_address1), .fb_ack(fb_ack1), .fb_data(fb_data1),
      .cpu_access(cpu_access1), .cpu_wr_en(cpu_wr_en1), .cpu_address(cpu_address1),
      .cpu_bytesel(cpu_bytesel1), .cpu_wdata(cpu_wdata1), .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
      .ram_addr(ram_addr1), .ram_wr_en(ram_wr_en1), .ram_be(ram_be1), .ram_wdata(ram_wdata1),
      .ram_rdata(ram_rdata1)
   );

   fb_mem_responder #(.RD_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset),
      .fb_access(fb_access3), .fb_address(fb_address3), .fb_ack(fb_ack3), .fb_data(fb_data3),
      .cpu_access(cpu_access3), .cpu_wr_en(cpu_wr_en3), .cpu_address(cpu_address3),
      .cpu_bytesel(cpu_bytesel3), .cpu_wdata(cpu_wdata3), .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
      .ram_addr(ram_addr3), .ram_wr_en(ram_wr_en3), .ram_be(ram_be3), .ram_wdata(ram_wdata3),
      .ram_rdata(ram_rdata3)
   );

   // Video RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_wr_en1) begin
         if (ram_be1[0]) mem1[ram_addr1][7:0]  <= ram_wdata1[7:0];
         if (ram_be1[1]) mem1[ram_addr1][15:8] <= ram_wdata1[15:8];
      end
      ram_rdata1 <= mem1[ram_addr1];
   end

   // Video RAM with three cycles of read latency.
   always @(posedge clk) begin
      if (ram_wr_en3) begin
         if (ram_be3[0]) mem3[ram_addr3][7:0]  <= ram_wdata3[7:0];
         if (ram_be3[1]) mem3[ram_addr3][15:8] <= ram_wdata3[15:8];
      end
      p3a        <= mem3[ram_addr3];
      p3b        <= p3a;
      ram_rdata3 <= p3b;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_vga;
      logic        wr;
      logic [15:0] addr;
      logic [1:0]  be;
      logic [15:0] wdata;
      int          exp_ack;
      logic [15:0] exp_data;
      logic        exp_wr_en;
      logic [1:0]  exp_be;
   } vec_t;

   vec_t vecs [8];

   // One isolated transaction on the L=1 instance, checked cycle by cycle.
   task automatic run_vec(input vec_t v);
      logic [1:0] exp_acks;
      @(posedge clk); #1;
      fb_access1   = v.is_vga;
      fb_address1  = v.addr;
      cpu_access1  = !v.is_vga;
      cpu_wr_en1   = v.wr;
      cpu_address1 = v.addr;
      cpu_bytesel1 = v.be;
      cpu_wdata1   = v.wdata;
      for (int c = 0; c <= v.exp_ack + 1; c++) begin
         @(negedge clk);
         exp_acks = (c == v.exp_ack) ? (v.is_vga ? 2'b10 : 2'b01) : 2'b00;
         check("vec_acks", {30'd0, fb_ack1, cpu_ack1}, {30'd0, exp_acks});
         if (c == 1) begin
            check("vec_ram_addr", {16'd0, ram_addr1}, {16'd0, v.addr});
            check("vec_ram_wr_en", {31'd0, ram_wr_en1}, {31'd0, v.exp_wr_en});
            check("vec_ram_be", {30'd0, ram_be1}, {30'd0, v.exp_be});
            if (v.wr) check("vec_ram_wdata", {16'd0, ram_wdata1}, {16'd0, v.wdata});
         end
         if (c != 1) check("vec_wr_en_idle", {31'd0, ram_wr_en1}, 32'd0);
         if ((c == v.exp_ack) && !v.wr) begin
            if (v.is_vga) check("vec_fb_data", {16'd0, fb_data1}, {16'd0, v.exp_data});
            else          check("vec_cpu_rdata", {16'd0, cpu_rdata1}, {16'd0, v.exp_data});
         end
         @(posedge clk); #1;
         if (c == v.exp_ack) begin
            fb_access1  = 1'b0;
            cpu_access1 = 1'b0;
         end
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 16'h1234, 2'b11, 16'hBEEF, 2, 16'h0000, 1'b1, 2'b11};
      vecs[1] = '{1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, 3, 16'hBEEF, 1'b0, 2'b11};
      vecs[2] = '{1'b0, 1'b1, 16'h0010, 2'b11, 16'h1111, 2, 16'h0000, 1'b1, 2'b11};
      vecs[3] = '{1'b0, 1'b1, 16'h0010, 2'b10, 16'hA5C3, 2, 16'h0000, 1'b1, 2'b10};
      vecs[4] = '{1'b0, 1'b0, 16'h0010, 2'b11, 16'h0000, 3, 16'hA511, 1'b0, 2'b11};
      vecs[5] = '{1'b0, 1'b1, 16'h0010, 2'b00, 16'hFFFF, 2, 16'h0000, 1'b0, 2'b00};
      vecs[6] = '{1'b0, 1'b0, 16'h0010, 2'b11, 16'h0000, 3, 16'hA511, 1'b0, 2'b11};
      vecs[7] = '{1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, 3, 16'hA511, 1'b0, 2'b11};

      reset = 1'b0;
      fb_access1 = 0; fb_address1 = 0; cpu_access1 = 0; cpu_wr_en1 = 0;
      cpu_address1 = 0; cpu_bytesel1 = 0; cpu_wdata1 = 0;
      fb_access3 = 0; fb_address3 = 0; cpu_access3 = 0; cpu_wr_en3 = 0;
      cpu_address3 = 0; cpu_bytesel3 = 0; cpu_wdata3 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_fb_ack", {31'd0, fb_ack1}, 32'd0);
      check("rst_cpu_ack", {31'd0, cpu_ack1}, 32'd0);
      check("rst_ram_wr_en", {31'd0, ram_wr_en1}, 32'd0);
      check("rst_ram_addr", {16'd0, ram_addr1}, 32'd0);
      check("rst_ram_be", {30'd0, ram_be1}, 32'd0);
      check("rst_ram_wdata", {16'd0, ram_wdata1}, 32'd0);
      check("rst_fb_data", {16'd0, fb_data1}, 32'd0);
      check("rst_cpu_rdata", {16'd0, cpu_rdata1}, 32'd0);
      check("rst_acks_l3", {30'd0, fb_ack3, cpu_ack3}, 32'd0);
      check("rst_cpu_rdata_l3", {16'd0, cpu_rdata3}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Both requesters held high from reset: grants alternate VGA, CPU, ...
      @(posedge clk); #1;
      reset = 1'b0;
      fb_access1 = 1'b1; fb_address1 = 16'h1234;
      cpu_access1 = 1'b1; cpu_wr_en1 = 1'b0; cpu_address1 = 16'h0010; cpu_bytesel1 = 2'b11;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         logic [1:0] exp_rr;
         @(negedge clk);
         exp_rr = ((c % 4) == 3) ? ((((c / 4) % 2) == 0) ? 2'b10 : 2'b01) : 2'b00;
         check("rr_acks", {30'd0, fb_ack1, cpu_ack1}, {30'd0, exp_rr});
         if (exp_rr == 2'b10) check("rr_fb_data", {16'd0, fb_data1}, 32'h0000BEEF);
         if (exp_rr == 2'b01) check("rr_cpu_rdata", {16'd0, cpu_rdata1}, 32'h0000A511);
         @(posedge clk); #1;
      end
      fb_access1 = 1'b0; cpu_access1 = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;

      // Reset during WAIT of a VGA read: the read is dropped without an ack.
      fb_access1 = 1'b1; fb_address1 = 16'h1234;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0; fb_access1 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int c = 3; c <= 8; c++) begin
         @(negedge clk);
         check("abort_acks", {30'd0, fb_ack1, cpu_ack1}, 32'd0);
         @(posedge clk); #1;
      end
      check("abort_fb_data", {16'd0, fb_data1}, 32'd0);
      run_vec(vecs[1]);

      // Reset sampled while a write is in ISSUE: the strobe drops next cycle, no ack.
      @(posedge clk); #1;
      cpu_access1 = 1'b1; cpu_wr_en1 = 1'b1; cpu_address1 = 16'h0020;
      cpu_bytesel1 = 2'b11; cpu_wdata1 = 16'h5555;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("wrst_wr_en_issue", {31'd0, ram_wr_en1}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1; cpu_access1 = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         check("wrst_wr_en", {31'd0, ram_wr_en1}, 32'd0);
         check("wrst_acks", {30'd0, fb_ack1, cpu_ack1}, 32'd0);
         @(posedge clk); #1;
      end

      // L=3: write a word, then hold a VGA read across two back-to-back reads.
      cpu_access3 = 1'b1; cpu_wr_en3 = 1'b1; cpu_address3 = 16'h0042;
      cpu_bytesel3 = 2'b11; cpu_wdata3 = 16'hCAFE;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         check("l3_wr_ack", {30'd0, fb_ack3, cpu_ack3}, (c == 2) ? 32'd1 : 32'd0);
         if (c == 1) check("l3_wr_en", {31'd0, ram_wr_en3}, 32'd1);
         @(posedge clk); #1;
         if (c == 2) cpu_access3 = 1'b0;
      end
      fb_access3 = 1'b1; fb_address3 = 16'h0042;
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         check("l3_rd_acks", {30'd0, fb_ack3, cpu_ack3},
               ((c == 5) || (c == 11)) ? 32'd2 : 32'd0);
         if ((c == 5) || (c == 11)) check("l3_fb_data", {16'd0, fb_data3}, 32'h0000CAFE);
         if ((c == 1) || (c == 7)) check("l3_ram_addr", {16'd0, ram_addr3}, 32'h00000042);
         @(posedge clk); #1;
         if (c == 11) fb_access3 = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fb_mem_responder.md
# fb_mem_responder

Responder end of the framebuffer memory port. Serves word reads issued by the VGA framebuffer prefetcher (`fb_access`/`fb_address`/`fb_ack`/`fb_data`) and word/byte accesses from the CPU video-memory window. Both are arbitrated onto one single-port synchronous video RAM. Sits in the `sys_clk` domain between the VGA prefetch logic, the CPU data bus and the video RAM.

## Interface
Parameters:
- `RD_LATENCY`, default 1: video RAM read latency in cycles; legal range 1–3.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `fb_access` in 1: VGA read request; held high until `fb_ack`.
- `fb_address` in 16: VGA word address; stable while `fb_access` is high.
- `fb_ack` out 1: single-cycle pulse that completes a VGA read.
- `fb_data` out 16: read word; valid only while `fb_ack` is high.
- `cpu_access` in 1: CPU request; held high until `cpu_ack`.
- `cpu_wr_en` in 1: 1 = write, 0 = read.
- `cpu_address` in 16: CPU word address.
- `cpu_bytesel` in 2: byte enables; bit 0 selects [7:0], bit 1 selects [15:8].
- `cpu_wdata` in 16: write data.
- `cpu_ack` out 1: single-cycle completion pulse.
- `cpu_rdata` out 16: read word; valid while `cpu_ack` is high.
- `ram_addr` out 16: RAM word address.
- `ram_wr_en` out 1: RAM write strobe.
- `ram_be` out 2: RAM byte enables.
- `ram_wdata` out 16: RAM write data.
- `ram_rdata` in 16: RAM read data, `RD_LATENCY` cycles after the address.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any request is high, grant one and register the requester, address, write flag, byte enables and data. Next state is ISSUE.
- Arbitration when both requests are high: round-robin on the last granted requester. After reset, last = CPU, so VGA wins the first tie. A lone requester is always granted.
- ISSUE: drive the RAM from the registered copies. `ram_wr_en` is high only for a CPU write. `ram_be` = `cpu_bytesel` for writes and 2'b11 for reads.
  - Write: next state is ACK.
  - Read: next state is WAIT.
- WAIT: count `RD_LATENCY` cycles. On the final count, capture `ram_rdata` into the data register of the granted requester. Next state is ACK.
- ACK: pulse the ack of the granted requester only. Next state is IDLE.
- A request still high in the cycle after ACK is treated as a new request.
- No request is accepted in ISSUE, WAIT or ACK. A request raised during those states waits in IDLE arbitration.
- A CPU write with `cpu_bytesel` = 2'b00 still runs the full sequence and is acked, with `ram_wr_en` = 0.
- Addresses are not decoded; 16 bits address 64K words.

## Timing
Cycle 0 is the first cycle in which the request is high and the FSM is in IDLE.
- Read: `ram_addr` is driven in cycle 1. `ram_rdata` is valid in cycle 1+L. `fb_ack` (or `cpu_ack`) is high in cycle 2+L with data on the same cycle.
- Write: RAM write in cycle 1; `cpu_ack` in cycle 2.
- Throughput: one read per 3+L cycles; one write per 3 cycles.
- Outputs are registered. Outside ISSUE, `ram_wr_en` = 0, and `ram_addr`, `ram_be` and `ram_wdata` hold their last values.
- Reset values: FSM = IDLE; `fb_ack`, `cpu_ack`, `ram_wr_en` = 0; `fb_data`, `cpu_rdata`, `ram_addr`, `ram_wdata` = 0; `ram_be` = 0; last-grant = CPU.
- Reset mid-transaction aborts the transaction with no ack. A write in ISSUE when reset is sampled low is suppressed: `ram_wr_en` is 0 in the next cycle.
- Simultaneous requests arriving while the FSM is in ACK are arbitrated in the following IDLE cycle.

## Structure
- Shared video package: the `fb_resp_state_t` enum (IDLE, ISSUE, WAIT, ACK) and a `fb_requester_t` enum (REQ_VGA, REQ_CPU).
- One natural sub-module: `fb_rd_latency_counter`. It counts WAIT cycles from `RD_LATENCY` and produces a `capture` strobe.
- The arbiter and FSM stay in `fb_mem_responder`.

## Test plan
- Single VGA read, L=1, RAM[0x1234]=0xBEEF, `fb_address`=0x1234 → `ram_addr`=0x1234 in cycle 1; `fb_ack`=1 with `fb_data`=0xBEEF in cycle 3 only.
- CPU write 0xA5C3 to 0x0010 with bytesel=2'b10, then a read → RAM[0x0010] high byte = 0xA5 and low byte unchanged; write ack in cycle 2.
- VGA and CPU both requesting continuously from reset → grants alternate VGA, CPU, VGA, … Each ack goes only to its owner and the other ack stays 0.
- L=3 read → `fb_ack` in cycle 5; `fb_access` held high after the ack produces a second read acked in cycle 11.
- Reset pulled low in WAIT of a VGA read → no `fb_ack` is ever asserted. After release, the first request completes with normal latency.
- CPU write with bytesel=2'b00 → `ram_wr_en` stays 0 and `cpu_ack` still pulses in cycle 2.
